// File: rtl/adc_capture.sv
// adc_capture: SAR conversion sequencer with ready-edge capture, 2^N averager and FWFT result FIFO
module adc_capture #(
  parameter int RESOLUTION = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PERIOD_W   = 16,
  localparam int CW = $clog2(FIFO_DEPTH + 1),
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic [PERIOD_W-1:0]   period_i,
  input  logic [1:0]            avg_log2_i,
  output logic                  start_o,
  input  logic                  adc_rdy_i,
  input  logic [RESOLUTION-1:0] adc_result_i,
  output logic [RESOLUTION-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [CW-1:0]         count_o,
  output logic                  overflow_o,
  output logic                  late_o
);
  logic [PERIOD_W-1:0]   timer;
  logic                  busy, rdy_q;
  logic [RESOLUTION+2:0] acc, sum;
  logic [3:0]            cnt;
  logic [1:0]            win, cur_win;
  logic [RESOLUTION-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  tick, rise, done, full, pop, push, drop;
  logic [RESOLUTION-1:0] avg_word;
  always_comb begin
    tick     = enable_i && timer == '0;
    rise     = adc_rdy_i && !rdy_q;
    cur_win  = cnt == 4'd0 ? avg_log2_i : win;
    sum      = acc + {3'b000, adc_result_i};
    done     = enable_i && rise && (cnt + 4'd1 == 4'd1 << cur_win);
    avg_word = RESOLUTION'(sum >> cur_win);
    valid_o  = count_o != '0;
    full     = count_o == CW'(FIFO_DEPTH);
    pop      = valid_o && ready_i;
    push     = done && (!full || pop);
    drop     = done && full && !pop;
    data_o   = valid_o ? mem[rd_ptr] : '0;
  end
  // Timer, start pulse and SAR busy tracking are untouched by clear_i
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer   <= '0;
      start_o <= 1'b0;
      busy    <= 1'b0;
      rdy_q   <= 1'b0;
      late_o  <= 1'b0;
    end else begin
      timer   <= !enable_i ? '0 : tick ? period_i : timer - PERIOD_W'(1);
      start_o <= tick && !busy;
      busy    <= (tick && !busy) ? 1'b1 : rise ? 1'b0 : busy;
      rdy_q   <= adc_rdy_i;
      late_o  <= !clear_i && (late_o || (tick && busy));
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc <= '0;
      cnt <= '0;
      win <= '0;
    end else if (clear_i || !enable_i) begin
      acc <= '0;
      cnt <= '0;
    end else if (rise) begin
      acc <= done ? '0 : sum;
      cnt <= done ? 4'd0 : cnt + 4'd1;
      win <= cur_win;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count_o    <= count_o + CW'(push) - CW'(pop);
      overflow_o <= overflow_o || drop;
    end
  end
  // Storage needs no reset: data_o is masked while the FIFO is empty
  always_ff @(posedge clk_i) begin
    if (push && !clear_i) mem[wr_ptr] <= avg_word;
  end
endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: directed stimulus with a SAR model and a queue-based reference of the averaged FIFO stream
module tb_adc_capture;
  localparam int RES = 8;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        rst_ni, enable_i, clear_i, start_o, adc_rdy_i, valid_o, ready_i, overflow_o, late_o;
  logic [15:0] period_i;
  logic [1:0]  avg_log2_i;
  logic [7:0]  adc_result_i, data_o;
  logic [2:0]  count_o;
  int          vectors = 0, errors = 0;
  bit          sar_auto;
  logic        man_rdy;
  logic [7:0]  man_res, sar_dflt;
  logic [7:0]  sar_q[$];
  logic [7:0]  mq[$];
  logic [7:0]  ms[$];
  bit          m_ovf;

  adc_capture #(.RESOLUTION(RES), .FIFO_DEPTH(DEPTH), .PERIOD_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .clear_i(clear_i),
    .period_i(period_i), .avg_log2_i(avg_log2_i), .start_o(start_o),
    .adc_rdy_i(adc_rdy_i), .adc_result_i(adc_result_i), .data_o(data_o),
    .valid_o(valid_o), .ready_i(ready_i), .count_o(count_o),
    .overflow_o(overflow_o), .late_o(late_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
  endtask

  // SAR: result ready RES+2 cycles after an accepted start; starts while converting are ignored
  initial begin : sar
    int sar_cnt = 0;
    adc_rdy_i = 1'b0;
    adc_result_i = '0;
    forever begin
      @(negedge clk);
      if (!sar_auto) begin
        adc_rdy_i = man_rdy;
        adc_result_i = man_res;
        sar_cnt = 0;
      end else if (start_o && sar_cnt == 0) begin
        adc_rdy_i = 1'b0;
        sar_cnt = RES + 2;
      end else if (sar_cnt > 0) begin
        sar_cnt--;
        if (sar_cnt == 0) begin
          adc_rdy_i = 1'b1;
          adc_result_i = sar_q.size() != 0 ? sar_q.pop_front() : sar_dflt;
        end
      end
    end
  end

  // Reference: collect 2^N captured results, push their truncated mean into a bounded queue
  initial begin : model
    bit   m_prev, full, pop, push;
    int   m_win, s;
    logic [7:0] w;
    m_prev = 1'b0;
    m_win = 0;
    forever begin
      @(posedge clk);
      if (!rst_ni) begin
        mq.delete();
        ms.delete();
        m_ovf = 1'b0;
        m_prev = 1'b0;
      end else begin
        full = mq.size() == DEPTH;
        pop = mq.size() != 0 && ready_i;
        push = 1'b0;
        w = '0;
        if (clear_i) begin
          mq.delete();
          ms.delete();
          m_ovf = 1'b0;
        end else begin
          if (!enable_i) ms.delete();
          else if (adc_rdy_i && !m_prev) begin
            if (ms.size() == 0) m_win = int'(avg_log2_i);
            ms.push_back(adc_result_i);
            if (ms.size() == (1 << m_win)) begin
              s = 0;
              foreach (ms[i]) s += int'(ms[i]);
              w = 8'(s >> m_win);
              ms.delete();
              push = 1'b1;
            end
          end
          if (pop) void'(mq.pop_front());
          if (push) begin
            if (full && !pop) m_ovf = 1'b1;
            else mq.push_back(w);
          end
        end
        m_prev = adc_rdy_i;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      #1;
      if (rst_ni) begin
        chk("count", int'(count_o), mq.size());
        chk("valid", int'(valid_o), int'(mq.size() != 0));
        if (mq.size() != 0) chk("data", int'(data_o), int'(mq[0]));
        chk("overflow", int'(overflow_o), int'(m_ovf));
      end
    end
  end

  initial begin : main
    rst_ni = 1'b0; enable_i = 1'b0; clear_i = 1'b0; period_i = '0; avg_log2_i = '0;
    ready_i = 1'b0; sar_auto = 1'b0; man_rdy = 1'b0; man_res = '0; sar_dflt = '0;
    // reset with random inputs
    repeat (6) begin
      @(negedge clk);
      enable_i = 1'($urandom); clear_i = 1'($urandom); period_i = 16'($urandom);
      avg_log2_i = 2'($urandom); ready_i = 1'($urandom); man_rdy = 1'($urandom); man_res = 8'($urandom);
      #1;
      chk("rst_start", int'(start_o), 0);
      chk("rst_data", int'(data_o), 0);
      chk("rst_valid", int'(valid_o), 0);
      chk("rst_count", int'(count_o), 0);
      chk("rst_ovf", int'(overflow_o), 0);
      chk("rst_late", int'(late_o), 0);
    end
    @(negedge clk);
    enable_i = 1'b0; clear_i = 1'b0; ready_i = 1'b0; man_rdy = 1'b0; period_i = 16'd5;
    @(negedge clk);
    rst_ni = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("idle_start", int'(start_o), 0);
    end
    sar_auto = 1'b1;
    // periodic single-sample capture
    period_i = 16'd19; avg_log2_i = 2'd0; ready_i = 1'b1; sar_dflt = 8'h5A; enable_i = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      chk("t2_start", int'(start_o), int'(c % 20 == 1));
      chk("t2_valid", int'(valid_o), int'(c % 20 == 12));
      if (valid_o) chk("t2_data", int'(data_o), 8'h5A);
      if (c == 80) begin
        chk("t2_late", int'(late_o), 0);
        enable_i = 1'b0;
      end
    end
    idle(20);
    // 4-sample average
    sar_q = '{8'd10, 8'd11, 8'd12, 8'd14};
    avg_log2_i = 2'd2; ready_i = 1'b0; enable_i = 1'b1;
    for (int c = 1; c <= 75; c++) begin
      @(negedge clk);
      if (c == 71) chk("t3_count_pre", int'(count_o), 0);
      if (c == 72) begin
        chk("t3_count", int'(count_o), 1);
        chk("t3_data", int'(data_o), 11);
      end
      if (c == 75) enable_i = 1'b0;
    end
    avg_log2_i = 2'd0;
    idle(20);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    chk("t3_drained", int'(valid_o), 0);
    // overflow with consumer stalled
    sar_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    enable_i = 1'b1;
    for (int c = 1; c <= 95; c++) begin
      @(negedge clk);
      if (c == 92) begin
        chk("t4_count", int'(count_o), 4);
        chk("t4_ovf", int'(overflow_o), 1);
      end
      if (c == 95) enable_i = 1'b0;
    end
    idle(20);
    chk("t4_rd1", int'(data_o), 1);
    ready_i = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk("t4_rd", int'(data_o), k);
    end
    @(negedge clk);
    ready_i = 1'b0;
    chk("t4_empty", int'(valid_o), 0);
    chk("t4_ovf_sticky", int'(overflow_o), 1);
    pulse_clear();
    chk("t4_ovf_clr", int'(overflow_o), 0);
    // full FIFO with simultaneous push and pop
    sar_q = '{8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    enable_i = 1'b1;
    for (int c = 1; c <= 95; c++) begin
      @(negedge clk);
      if (c == 91) begin
        chk("t4b_full", int'(count_o), 4);
        ready_i = 1'b1;
      end
      if (c == 92) begin
        chk("t4b_count", int'(count_o), 4);
        chk("t4b_ovf", int'(overflow_o), 0);
        chk("t4b_head", int'(data_o), 7);
        ready_i = 1'b0;
      end
      if (c == 95) enable_i = 1'b0;
    end
    idle(20);
    pulse_clear();
    // period shorter than conversion: dropped ticks
    period_i = 16'd3; ready_i = 1'b1; sar_dflt = 8'h33; enable_i = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      chk("t5_start", int'(start_o), int'(c % 12 == 1));
      chk("t5_late", int'(late_o), int'(c >= 5));
      if (c == 60) enable_i = 1'b0;
    end
    idle(20);
    pulse_clear();
    chk("t5_late_clr", int'(late_o), 0);
    chk("t5_valid_clr", int'(valid_o), 0);
    // reset in the middle of a conversion
    period_i = 16'd19; sar_dflt = 8'h77; enable_i = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      chk("t6_start", int'(start_o), int'(c == 1 || c == 7 || c == 27));
      if (c == 5) chk("t6_rst_valid", int'(valid_o), 0);
      if (c >= 8) chk("t6_late", int'(late_o), 0);
      if (c == 12) begin
        chk("t6_valid", int'(valid_o), 1);
        chk("t6_data", int'(data_o), 8'h77);
      end
      if (c == 4) rst_ni = 1'b0;
      if (c == 6) rst_ni = 1'b1;
    end
    enable_i = 1'b0;
    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
